// File: rtl/conv_pkg.sv
// Shared state encoding, read-select codes and a small elaboration helper
// for the convolution tile sequencer.
package conv_pkg;

    localparam int unsigned STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        IDLE    = 3'd0,
        WLOAD   = 3'd1,
        FSTREAM = 3'd2,
        DRAIN   = 3'd3,
        DONE    = 3'd4
    } state_t;

    localparam logic SEL_FEAT = 1'b0;
    localparam logic SEL_WGT  = 1'b1;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/conv_addr_gen.sv
// Two-level index counter: each inner step adds OFFSET to the address; an inner
// wrap bumps the outer index and restarts the address at the new outer base.
module conv_addr_gen #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned CNT_W      = 4,
    parameter int unsigned OFFSET     = 14
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_clear,
    input  logic                  i_en,
    input  logic [CNT_W-1:0]      i_inner_last,
    input  logic [CNT_W-1:0]      i_outer_last,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic                  o_inner_wrap,
    output logic                  o_outer_wrap
);

    localparam logic [ADDR_WIDTH:0] STRIDE = (ADDR_WIDTH + 1)'(OFFSET);

    logic [CNT_W-1:0]      r_inner;
    logic [CNT_W-1:0]      r_outer;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH-1:0] r_base;
    logic [ADDR_WIDTH:0]   w_step;
    logic [ADDR_WIDTH:0]   w_next_base;

    assign w_step       = {1'b0, r_addr} + STRIDE;
    assign w_next_base  = {1'b0, r_base} + (ADDR_WIDTH + 1)'(1);
    assign o_inner_wrap = (r_inner == i_inner_last);
    assign o_outer_wrap = (r_outer == i_outer_last);
    assign o_addr       = r_addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inner <= '0;
            r_outer <= '0;
            r_addr  <= '0;
            r_base  <= '0;
        end else if (i_clear) begin
            r_inner <= '0;
            r_outer <= '0;
            r_addr  <= '0;
            r_base  <= '0;
        end else if (i_en) begin
            if (o_inner_wrap) begin
                r_inner <= '0;
                if (o_outer_wrap) begin
                    r_outer <= '0;
                    r_addr  <= '0;
                    r_base  <= '0;
                end else begin
                    r_outer <= r_outer + CNT_W'(1);
                    r_addr  <= w_next_base[ADDR_WIDTH-1:0];
                    r_base  <= w_next_base[ADDR_WIDTH-1:0];
                end
            end else begin
                r_inner <= r_inner + CNT_W'(1);
                r_addr  <= w_step[ADDR_WIDTH-1:0];
            end
        end
    end

endmodule

// File: rtl/conv_seq_ctrl.sv
// Convolution tile sequencer: weight-row reads, column-major feature reads, drain, done.
// Optional macro CONV_SEQ_PERF_EN adds the stall_cnt_o stall-cycle counter.
module conv_seq_ctrl
    import conv_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned ROW_CNT    = 14,
    parameter int unsigned COL_CNT    = 14,
    parameter int unsigned W_CNT      = 8,
    parameter int unsigned OFFSET     = 14,
    parameter int unsigned DRAIN_LAT  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic                  abort_i,
    input  logic                  stall_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  rd_en_o,
    output logic [ADDR_WIDTH-1:0] rd_addr_o,
    output logic                  rd_sel_o,
`ifdef CONV_SEQ_PERF_EN
    output logic [15:0]           stall_cnt_o,
`endif
    output logic                  last_o
);

    localparam int unsigned CNT_W    = $clog2(max3(W_CNT, ROW_CNT, COL_CNT) + 1);
    localparam int unsigned DRN_W    = $clog2(DRAIN_LAT + 1);
    localparam int          DRN_LAST = int'(DRAIN_LAT) - 2;

    if (((COL_CNT - 1) + (ROW_CNT - 1) * OFFSET >= (1 << ADDR_WIDTH)) ||
        ((W_CNT - 1) * OFFSET >= (1 << ADDR_WIDTH)) || (DRAIN_LAT < 1)) begin : g_param_err
        $error("conv_seq_ctrl: address range exceeds ADDR_WIDTH or DRAIN_LAT < 1");
    end

    state_t                r_state;
    state_t                w_state_nxt;
    logic [DRN_W-1:0]      r_drain;
    logic [DRN_W-1:0]      w_drain_nxt;
    logic                  w_issue;
    logic                  w_start_ok;
    logic                  w_ag_en;
    logic                  w_ag_clear;
    logic                  w_inner_wrap;
    logic                  w_outer_wrap;
    logic [CNT_W-1:0]      w_inner_last;
    logic [CNT_W-1:0]      w_outer_last;
    logic [ADDR_WIDTH-1:0] w_addr;

    assign w_issue      = ((r_state == WLOAD) || (r_state == FSTREAM)) && !stall_i;
    assign w_start_ok   = (r_state == IDLE) && start_i && !abort_i;
    assign w_inner_last = (r_state == WLOAD) ? CNT_W'(W_CNT - 1) : CNT_W'(ROW_CNT - 1);
    assign w_outer_last = (r_state == WLOAD) ? '0 : CNT_W'(COL_CNT - 1);

    conv_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .CNT_W      (CNT_W),
        .OFFSET     (OFFSET)
    ) u_addr_gen (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_clear      (w_ag_clear),
        .i_en         (w_ag_en),
        .i_inner_last (w_inner_last),
        .i_outer_last (w_outer_last),
        .o_addr       (w_addr),
        .o_inner_wrap (w_inner_wrap),
        .o_outer_wrap (w_outer_wrap)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_drain <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_drain <= w_drain_nxt;
        end
    end

    // The last-read cycle counts as the first drain cycle, so done_o lands
    // exactly DRAIN_LAT cycles after the final feature strobe.
    always_comb begin
        w_state_nxt = r_state;
        w_drain_nxt = r_drain;
        w_ag_en     = 1'b0;
        w_ag_clear  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_start_ok) begin
                    w_state_nxt = WLOAD;
                    w_ag_clear  = 1'b1;
                end
            end
            WLOAD: begin
                if (w_issue) begin
                    w_ag_en = 1'b1;
                    if (w_inner_wrap) begin
                        w_state_nxt = FSTREAM;
                        w_ag_clear  = 1'b1;
                    end
                end
            end
            FSTREAM: begin
                if (w_issue) begin
                    w_ag_en = 1'b1;
                    if (w_inner_wrap && w_outer_wrap) begin
                        w_state_nxt = (DRAIN_LAT == 1) ? DONE : DRAIN;
                        w_ag_clear  = 1'b1;
                        w_drain_nxt = '0;
                    end
                end
            end
            DRAIN: begin
                if (int'(r_drain) >= DRN_LAST) begin
                    w_state_nxt = DONE;
                    w_drain_nxt = '0;
                end else begin
                    w_drain_nxt = r_drain + DRN_W'(1);
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
                w_ag_clear  = 1'b1;
                w_drain_nxt = '0;
            end
        endcase
        if (abort_i) begin
            w_state_nxt = IDLE;
            w_ag_clear  = 1'b1;
            w_drain_nxt = '0;
        end
    end

    assign busy_o    = (r_state != IDLE);
    assign done_o    = (r_state == DONE);
    assign rd_en_o   = w_issue;
    assign rd_addr_o = w_issue ? w_addr : '0;
    assign rd_sel_o  = (w_issue && (r_state == WLOAD)) ? SEL_WGT : SEL_FEAT;
    assign last_o    = w_issue && (r_state == FSTREAM) && w_inner_wrap && w_outer_wrap;

`ifdef CONV_SEQ_PERF_EN
    logic [15:0] r_stall_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (w_start_ok) begin
            r_stall_cnt <= '0;
        end else if (stall_i && ((r_state == WLOAD) || (r_state == FSTREAM)) &&
                     (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign stall_cnt_o = r_stall_cnt;
`endif

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Self-checking bench for conv_seq_ctrl: read sequences are compared against a
// list built from the weight/feature indexing rules with plain arithmetic.
`timescale 1ns/1ps
module tb_conv_seq_ctrl;

    localparam int AW     = 8;
    localparam int ROWS   = 14;
    localparam int COLS   = 14;
    localparam int WN     = 8;
    localparam int OFF    = 14;
    localparam int DLAT   = 4;
    localparam int NFEAT  = ROWS * COLS;
    localparam int NREAD  = WN + NFEAT;
    localparam int BUDGET = 2000;

    typedef struct packed {
        logic          sel;
        logic [AW-1:0] addr;
        logic          last;
    } rd_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start_i = 1'b0;
    logic          abort_i = 1'b0;
    logic          stall_i = 1'b0;
    logic          busy_o, done_o, rd_en_o, rd_sel_o, last_o;
    logic [AW-1:0] rd_addr_o;
`ifdef CONV_SEQ_PERF_EN
    logic [15:0]   stall_cnt_o;
`endif

    int   total = 0;
    int   bad = 0;
    rd_t  got[$];
    rd_t  expq[$];
    int   gcyc = 0;
    int   n_done = 0;
    int   n_last = 0;
    int   t_last = -1;
    int   t_done = -1;
    int   t_first = -1;
    int   t_start = -1;
    logic done_busy = 1'b0;
    logic last_busy = 1'b0;

    always #5 clk = ~clk;

    conv_seq_ctrl #(
        .ADDR_WIDTH (AW),
        .ROW_CNT    (ROWS),
        .COL_CNT    (COLS),
        .W_CNT      (WN),
        .OFFSET     (OFF),
        .DRAIN_LAT  (DLAT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (start_i),
        .abort_i     (abort_i),
        .stall_i     (stall_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .rd_en_o     (rd_en_o),
        .rd_addr_o   (rd_addr_o),
        .rd_sel_o    (rd_sel_o),
`ifdef CONV_SEQ_PERF_EN
        .stall_cnt_o (stall_cnt_o),
`endif
        .last_o      (last_o)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic observe();
        rd_t e;
        gcyc++;
        last_busy = busy_o;
        if (rd_en_o === 1'b1) begin
            if (got.size() == 0) t_first = gcyc;
            e = {rd_sel_o, rd_addr_o, last_o};
            got.push_back(e);
        end
        if (last_o === 1'b1) begin
            n_last++;
            t_last = gcyc;
        end
        if (done_o === 1'b1) begin
            n_done++;
            t_done = gcyc;
            done_busy = busy_o;
        end
    endtask

    // Inputs change 1 ns after the rising edge; outputs are sampled on the falling edge.
    task automatic step(input logic s, input logic st, input logic ab);
        stall_i = s;
        start_i = st;
        abort_i = ab;
        @(negedge clk);
        observe();
        @(posedge clk);
        #1;
    endtask

    function automatic void build_expect(input int nfeat);
        rd_t e;
        expq.delete();
        for (int k = 0; k < WN; k++) begin
            e.sel  = 1'b1;
            e.addr = AW'((k * OFF) % (1 << AW));
            e.last = 1'b0;
            expq.push_back(e);
        end
        for (int i = 0; i < nfeat; i++) begin
            int c;
            int r;
            c = i / ROWS;
            r = i % ROWS;
            e.sel  = 1'b0;
            e.addr = AW'((c + r * OFF) % (1 << AW));
            e.last = (i == NFEAT - 1);
            expq.push_back(e);
        end
    endfunction

    function automatic int first_diff();
        int n;
        n = (got.size() < expq.size()) ? got.size() : expq.size();
        for (int i = 0; i < n; i++)
            if (got[i] !== expq[i]) return i;
        if (got.size() != expq.size()) return n;
        return -1;
    endfunction

    function automatic string diff_text(input int idx);
        string sg, se;
        sg = (idx < got.size()) ? $sformatf("sel=%0d addr=%0d last=%0d", got[idx].sel,
                                            got[idx].addr, got[idx].last) : "none";
        se = (idx < expq.size()) ? $sformatf("sel=%0d addr=%0d last=%0d", expq[idx].sel,
                                             expq[idx].addr, expq[idx].last) : "none";
        return $sformatf("read #%0d got {%s} want {%s} (got %0d reads, want %0d)",
                         idx, sg, se, got.size(), expq.size());
    endfunction

    // mode: 0 no stall, 1 alternate stall in feature phase, 2 random, 3 fixed perf pattern
    task automatic run_tile(input int mode, input int abort_at, input bit hold_start);
        int   cyc;
        bit   stop;
        int   ws, fs, ds;
        logic s, ab, st;
        cyc = 0; stop = 0; ws = 0; fs = 0; ds = 0;
        got.delete();
        n_done = 0; n_last = 0; t_last = -1; t_done = -1; t_first = -1;
        done_busy = 1'b0;
        step(1'b0, 1'b1, 1'b0);
        t_start = gcyc;
        while (!stop && cyc < BUDGET) begin
            int nr;
            nr = got.size();
            s = 1'b0; ab = 1'b0; st = 1'b0;
            case (mode)
                1: s = (nr >= WN) && (nr < NREAD) && (cyc % 2 == 0);
                2: s = ($urandom_range(0, 3) == 0);
                3: begin
                    if (nr < WN && ws < 10) begin
                        s = 1'b1; ws++;
                    end else if (nr >= WN && nr < NREAD && fs < 20 && cyc % 3 == 0) begin
                        s = 1'b1; fs++;
                    end else if (nr == NREAD && ds < 3) begin
                        s = 1'b1; ds++;
                    end
                end
                default: s = 1'b0;
            endcase
            if (hold_start && nr >= WN && nr < NREAD) st = 1'b1;
            if (abort_at >= 0 && nr == WN + abort_at) begin
                ab = 1'b1;
                s  = 1'b0;
            end
            step(s, st, ab);
            cyc++;
            if (ab || n_done != 0) stop = 1;
        end
        if (!stop) begin
            total++; bad++;
            $display("FAIL run_tile_timeout: no done_o after %0d cycles (mode %0d)", cyc, mode);
        end
        stall_i = 1'b0; start_i = 1'b0; abort_i = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        total++; if (busy_o !== 1'b0)   begin bad++; $display("FAIL reset_busy: got %b want 0", busy_o); end
        total++; if (done_o !== 1'b0)   begin bad++; $display("FAIL reset_done: got %b want 0", done_o); end
        total++; if (rd_en_o !== 1'b0)  begin bad++; $display("FAIL reset_rd_en: got %b want 0", rd_en_o); end
        total++; if (rd_addr_o !== '0)  begin bad++; $display("FAIL reset_addr: got %0d want 0", rd_addr_o); end
        total++; if (rd_sel_o !== 1'b0) begin bad++; $display("FAIL reset_sel: got %b want 0", rd_sel_o); end
        total++; if (last_o !== 1'b0)   begin bad++; $display("FAIL reset_last: got %b want 0", last_o); end
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        total++; if (last_busy !== 1'b0) begin bad++; $display("FAIL idle_busy: got %b want 0", last_busy); end
    endtask

    task automatic test_basic();
        int d;
        run_tile(0, -1, 0);
        build_expect(NFEAT);
        d = first_diff();
        total++; if (d !== -1) begin bad++; $display("FAIL basic_seq: %s", diff_text(d)); end
        total++; if (got.size() !== NREAD) begin bad++; $display("FAIL basic_count: got %0d want %0d", got.size(), NREAD); end
        total++; if (t_first - t_start !== 1) begin bad++; $display("FAIL basic_first_lat: got %0d want 1", t_first - t_start); end
        total++; if (n_last !== 1) begin bad++; $display("FAIL basic_last_cnt: got %0d want 1", n_last); end
        total++; if (n_done !== 1) begin bad++; $display("FAIL basic_done_cnt: got %0d want 1", n_done); end
        total++; if (t_done - t_last !== DLAT) begin bad++; $display("FAIL basic_drain_lat: got %0d want %0d", t_done - t_last, DLAT); end
        total++; if (done_busy !== 1'b1) begin bad++; $display("FAIL basic_busy_in_done: got %b want 1", done_busy); end
        step(1'b0, 1'b0, 1'b0);
        total++; if (last_busy !== 1'b0) begin bad++; $display("FAIL basic_idle_after: got %b want 0", last_busy); end
        total++; if (n_done !== 1) begin bad++; $display("FAIL basic_done_pulse: got %0d want 1", n_done); end
    endtask

    task automatic test_stall_alt();
        int d;
        run_tile(1, -1, 0);
        build_expect(NFEAT);
        d = first_diff();
        total++; if (d !== -1) begin bad++; $display("FAIL stall_alt_seq: %s", diff_text(d)); end
        total++; if (got.size() !== NREAD) begin bad++; $display("FAIL stall_alt_count: got %0d want %0d", got.size(), NREAD); end
        total++; if (t_done - t_last !== DLAT) begin bad++; $display("FAIL stall_alt_drain: got %0d want %0d", t_done - t_last, DLAT); end
    endtask

    task automatic test_random_stall();
        int d;
        for (int rep = 0; rep < 3; rep++) begin
            run_tile(2, -1, 0);
            build_expect(NFEAT);
            d = first_diff();
            total++; if (d !== -1) begin bad++; $display("FAIL rand_stall_seq[%0d]: %s", rep, diff_text(d)); end
            total++; if (n_done !== 1) begin bad++; $display("FAIL rand_stall_done[%0d]: got %0d want 1", rep, n_done); end
            step(1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic test_abort();
        int d;
        int n_before;
        run_tile(0, 50, 0);
        build_expect(51);
        d = first_diff();
        total++; if (d !== -1) begin bad++; $display("FAIL abort_seq: %s", diff_text(d)); end
        step(1'b0, 1'b0, 1'b0);
        total++; if (last_busy !== 1'b0) begin bad++; $display("FAIL abort_busy: got %b want 0", last_busy); end
        n_before = got.size();
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0);
        total++; if (n_done !== 0) begin bad++; $display("FAIL abort_no_done: got %0d want 0", n_done); end
        total++; if (got.size() !== n_before) begin bad++; $display("FAIL abort_no_reads: got %0d want %0d", got.size(), n_before); end
        run_tile(0, -1, 0);
        build_expect(NFEAT);
        d = first_diff();
        total++; if (d !== -1) begin bad++; $display("FAIL abort_restart_seq: %s", diff_text(d)); end
        step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_start_ignored();
        int  d;
        bit  busy_seen;
        run_tile(0, -1, 1);
        build_expect(NFEAT);
        d = first_diff();
        total++; if (d !== -1) begin bad++; $display("FAIL hold_start_seq: %s", diff_text(d)); end
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        busy_seen = 0;
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b0, 1'b0);
            if (last_busy !== 1'b0) busy_seen = 1;
        end
        total++; if (busy_seen !== 1'b0) begin bad++; $display("FAIL start_abort_idle_busy: got 1 want 0"); end
        total++; if (got.size() !== NREAD) begin bad++; $display("FAIL start_abort_reads: got %0d want %0d", got.size(), NREAD); end
        total++; if (n_done !== 1) begin bad++; $display("FAIL hold_start_done: got %0d want 1", n_done); end
    endtask

    task automatic test_reset_mid();
        int d;
        got.delete();
        n_done = 0;
        step(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (rd_en_o !== 1'b0)  begin bad++; $display("FAIL rst_mid_rd_en: got %b want 0", rd_en_o); end
        total++; if (busy_o !== 1'b0)   begin bad++; $display("FAIL rst_mid_busy: got %b want 0", busy_o); end
        total++; if (rd_addr_o !== '0)  begin bad++; $display("FAIL rst_mid_addr: got %0d want 0", rd_addr_o); end
        total++; if (rd_sel_o !== 1'b0) begin bad++; $display("FAIL rst_mid_sel: got %b want 0", rd_sel_o); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b0);
        total++; if (n_done !== 0) begin bad++; $display("FAIL rst_mid_no_done: got %0d want 0", n_done); end
        run_tile(0, -1, 0);
        build_expect(NFEAT);
        d = first_diff();
        total++; if (d !== -1) begin bad++; $display("FAIL rst_mid_clean_seq: %s", diff_text(d)); end
        total++; if (t_done - t_last !== DLAT) begin bad++; $display("FAIL rst_mid_drain: got %0d want %0d", t_done - t_last, DLAT); end
        step(1'b0, 1'b0, 1'b0);
    endtask

`ifdef CONV_SEQ_PERF_EN
    task automatic test_perf();
        int d;
        run_tile(3, -1, 0);
        build_expect(NFEAT);
        d = first_diff();
        total++; if (d !== -1) begin bad++; $display("FAIL perf_seq: %s", diff_text(d)); end
        total++; if (stall_cnt_o !== 16'd30) begin bad++; $display("FAIL perf_stall_cnt: got %0d want 30", stall_cnt_o); end
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
        total++; if (stall_cnt_o !== 16'd30) begin bad++; $display("FAIL perf_hold: got %0d want 30", stall_cnt_o); end
        run_tile(0, -1, 0);
        total++; if (stall_cnt_o !== 16'd0) begin bad++; $display("FAIL perf_clear: got %0d want 0", stall_cnt_o); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_stall_alt();
        test_random_stall();
        test_abort();
        test_start_ignored();
        test_reset_mid();
`ifdef CONV_SEQ_PERF_EN
        test_perf();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
